// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM stage: memop encodings, FSM states and
// small decode helpers used by both the controller and the data formatter.
package mem_lsu_pkg;

   typedef enum logic [3:0] {
      MEMOP_NONE = 4'd0,
      MEMOP_LB   = 4'd1,
      MEMOP_LH   = 4'd2,
      MEMOP_LW   = 4'd3,
      MEMOP_LD   = 4'd4,
      MEMOP_LBU  = 4'd5,
      MEMOP_LHU  = 4'd6,
      MEMOP_LWU  = 4'd7,
      MEMOP_SB   = 4'd8,
      MEMOP_SH   = 4'd9,
      MEMOP_SW   = 4'd10,
      MEMOP_SD   = 4'd11
   } memop_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd7);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= 4'd8) && (op <= 4'd11);
   endfunction

   // Natural alignment check for the access size implied by the memop.
   function automatic logic is_misaligned(input logic [3:0] op, input logic [2:0] a);
      case (op)
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: return a[0];
         MEMOP_LW, MEMOP_LWU, MEMOP_SW: return |a[1:0];
         MEMOP_LD, MEMOP_SD:            return |a;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational data formatter: store lane replication / byte strobes and
// load byte extraction with sign or zero extension.
module lsu_fmt
   import mem_lsu_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int MEMOP_LEN = 4
) (
   input  logic [MEMOP_LEN-1:0] i_memop,
   input  logic [2:0]           i_addr_lo,
   input  logic [XLEN-1:0]      i_rs2,
   input  logic [XLEN-1:0]      i_rdata,
   output logic [XLEN-1:0]      o_wdata,
   output logic [7:0]           o_wstrb,
   output logic [XLEN-1:0]      o_load_data
);

   logic [XLEN-1:0] w_shifted;

   assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

   // Store data: replicate the operand across every lane, strobe the addressed bytes.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      o_wdata = '0;
      o_wstrb = '0;
      case (i_memop)
         MEMOP_SB: begin
            o_wdata = {(XLEN/8){i_rs2[7:0]}};
            o_wstrb = 8'h01 << i_addr_lo;
         end
         MEMOP_SH: begin
            o_wdata = {(XLEN/16){i_rs2[15:0]}};
            o_wstrb = 8'h03 << i_addr_lo;
         end
         MEMOP_SW: begin
            o_wdata = {(XLEN/32){i_rs2[31:0]}};
            o_wstrb = 8'h0F << i_addr_lo;
         end
         MEMOP_SD: begin
            o_wdata = i_rs2;
            o_wstrb = 8'hFF;
         end
         default: ;
      endcase
   end

   // Load data: pick the addressed bytes from the aligned doubleword and extend.
   always_comb begin
      o_load_data = w_shifted;
      case (i_memop)
         MEMOP_LB:  o_load_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
         MEMOP_LH:  o_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         MEMOP_LW:  o_load_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
         MEMOP_LBU: o_load_data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
         MEMOP_LHU: o_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
         MEMOP_LWU: o_load_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
         default:   o_load_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM pipeline stage: issues loads/stores on a req/gnt + rvalid port,
// stalls upstream while an access is outstanding and registers one result
// per instruction toward MEM/WB.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int XLEN          = 64,
   parameter int REG_ADDRWIDTH = 5,
   parameter int MEMOP_LEN     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   input  logic                     i_flush,
   input  logic [XLEN-1:0]          i_exc_alu_out,
   input  logic [XLEN-1:0]          i_exc_csr_out,
   input  logic                     i_exc_csr_valid,
   input  logic [XLEN-1:0]          i_rs2_data,
   input  logic [MEMOP_LEN-1:0]     i_memop,
   input  logic [REG_ADDRWIDTH-1:0] i_rd_idx,
   input  logic [XLEN-1:0]          i_pc,
   output logic                     o_stall,
   output logic                     o_valid,
   output logic [XLEN-1:0]          o_wb_data,
   output logic [REG_ADDRWIDTH-1:0] o_rd_idx,
   output logic [XLEN-1:0]          o_pc,
   output logic                     o_misalign,
   output logic                     o_dmem_req,
   output logic                     o_dmem_we,
   output logic [XLEN-1:0]          o_dmem_addr,
   output logic [XLEN-1:0]          o_dmem_wdata,
   output logic [7:0]               o_dmem_wstrb,
   input  logic                     i_dmem_gnt,
   input  logic                     i_dmem_rvalid,
   input  logic [XLEN-1:0]          i_dmem_rdata
);

   state_e                   r_state;
   logic [XLEN-1:0]          r_addr;
   logic [MEMOP_LEN-1:0]     r_memop;
   logic [REG_ADDRWIDTH-1:0] r_rd_idx;
   logic [XLEN-1:0]          r_pc;
   logic [XLEN-1:0]          r_rs2;

   logic                     r_valid;
   logic [XLEN-1:0]          r_wb_data;
   logic [REG_ADDRWIDTH-1:0] r_res_rd;
   logic [XLEN-1:0]          r_res_pc;
   logic                     r_misalign;

   logic                     w_in_idle;
   logic [MEMOP_LEN-1:0]     w_op;
   logic [XLEN-1:0]          w_addr;
   logic [XLEN-1:0]          w_rs2;
   logic                     w_accept;
   logic                     w_is_mem;
   logic                     w_misalign;
   logic                     w_issue;
   logic                     w_req;
   logic                     w_gnt;
   logic                     w_store_done;
   logic [XLEN-1:0]          w_wdata;
   logic [7:0]               w_wstrb;
   logic [XLEN-1:0]          w_load_data;

   // In IDLE the request is driven straight from EX/MEM; afterwards from the latched copy.
   assign w_in_idle    = (r_state == ST_IDLE);
   assign w_op         = w_in_idle ? i_memop       : r_memop;
   assign w_addr       = w_in_idle ? i_exc_alu_out : r_addr;
   assign w_rs2        = w_in_idle ? i_rs2_data    : r_rs2;

   assign w_accept     = !rst && w_in_idle && i_valid && !i_flush;
   assign w_is_mem     = is_load(i_memop) || is_store(i_memop);
   assign w_misalign   = is_misaligned(i_memop, i_exc_alu_out[2:0]);
   assign w_issue      = w_accept && w_is_mem && !w_misalign;
   assign w_req        = w_issue || (!rst && (r_state == ST_REQ) && !i_flush);
   assign w_gnt        = w_req && i_dmem_gnt;
   assign w_store_done = w_gnt && is_store(w_op);

   lsu_fmt #(
      .XLEN      (XLEN),
      .MEMOP_LEN (MEMOP_LEN)
   ) u_fmt (
      .i_memop     (w_op),
      .i_addr_lo   (w_addr[2:0]),
      .i_rs2       (w_rs2),
      .i_rdata     (i_dmem_rdata),
      .o_wdata     (w_wdata),
      .o_wstrb     (w_wstrb),
      .o_load_data (w_load_data)
   );

   assign o_dmem_req   = w_req;
   assign o_dmem_we    = w_req && is_store(w_op);
   assign o_dmem_addr  = w_req ? w_addr  : '0;
   assign o_dmem_wdata = w_req ? w_wdata : '0;
   assign o_dmem_wstrb = w_req ? w_wstrb : '0;

   // Hold upstream whenever an access is in flight and not finishing this cycle.
   assign o_stall = !rst && ((w_issue && !w_store_done)
                          || ((r_state == ST_REQ)  && !w_store_done)
                          || ((r_state == ST_WAIT) && !i_dmem_rvalid)
                          ||  (r_state == ST_DRAIN));

   assign o_valid    = r_valid;
   assign o_wb_data  = r_wb_data;
   assign o_rd_idx   = r_res_rd;
   assign o_pc       = r_res_pc;
   assign o_misalign = r_misalign;

   // Access FSM, operand latch and registered MEM/WB result.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_memop    <= '0;
         r_rd_idx   <= '0;
         r_pc       <= '0;
         r_rs2      <= '0;
         r_valid    <= 1'b0;
         r_wb_data  <= '0;
         r_res_rd   <= '0;
         r_res_pc   <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr   <= i_exc_alu_out;
                  r_memop  <= i_memop;
                  r_rd_idx <= i_rd_idx;
                  r_pc     <= i_pc;
                  r_rs2    <= i_rs2_data;
                  if (!w_is_mem) begin
                     r_valid   <= 1'b1;
                     r_wb_data <= i_exc_csr_valid ? i_exc_csr_out : i_exc_alu_out;
                     r_res_rd  <= i_rd_idx;
                     r_res_pc  <= i_pc;
                  end else if (w_misalign) begin
                     r_valid    <= 1'b1;
                     r_misalign <= 1'b1;
                     r_wb_data  <= i_exc_alu_out;
                     r_res_rd   <= '0;
                     r_res_pc   <= i_pc;
                  end else if (w_store_done) begin
                     r_valid   <= 1'b1;
                     r_wb_data <= i_exc_alu_out;
                     r_res_rd  <= '0;
                     r_res_pc  <= i_pc;
                  end else if (w_gnt) begin
                     r_state <= ST_WAIT;
                  end else begin
                     r_state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (i_flush) begin
                  r_state <= ST_IDLE;
               end else if (w_store_done) begin
                  r_state   <= ST_IDLE;
                  r_valid   <= 1'b1;
                  r_wb_data <= r_addr;
                  r_res_rd  <= '0;
                  r_res_pc  <= r_pc;
               end else if (w_gnt) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_dmem_rvalid) begin
                  r_state <= ST_IDLE;
                  // Data arriving together with a flush is simply dropped.
                  if (!i_flush) begin
                     r_valid   <= 1'b1;
                     r_wb_data <= w_load_data;
                     r_res_rd  <= r_rd_idx;
                     r_res_pc  <= r_pc;
                  end
               end else if (i_flush) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (i_dmem_rvalid) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM stage of the in-order pipeline. Consumes the EX/MEM pipeline register outputs and performs loads and stores over a req/gnt + rvalid data-memory port.
- Selects the writeback value and presents one registered result per instruction to the MEM/WB register.
- Raises o_stall so EX/MEM and earlier stages hold (their wen deasserted) while a memory access is outstanding.

Parameters:
XLEN, 64, datapath/address width
REG_ADDRWIDTH, 5, register index width
MEMOP_LEN, 4, memop encoding width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  EX/MEM holds a valid instruction
i_flush  in  1  discard in-flight/incoming instruction (trap redirect)
i_exc_alu_out  in  XLEN  effective address or ALU result
i_exc_csr_out  in  XLEN  old CSR value for CSR instructions
i_exc_csr_valid  in  1  instruction is a CSR op
i_rs2_data  in  XLEN  store data
i_memop  in  MEMOP_LEN  memory operation
i_rd_idx  in  REG_ADDRWIDTH  destination register
i_pc  in  XLEN  instruction PC
o_stall  out  1  hold upstream pipeline registers
o_valid  out  1  result valid (one cycle per instruction)
o_wb_data  out  XLEN  writeback value
o_rd_idx  out  REG_ADDRWIDTH  destination register (0 = no write)
o_pc  out  XLEN  PC of the result
o_misalign  out  1  load/store address misaligned
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1 = store
o_dmem_addr  out  XLEN  byte address
o_dmem_wdata  out  XLEN  lane-replicated store data
o_dmem_wstrb  out  8  byte strobes
i_dmem_gnt  in  1  request accepted this cycle
i_dmem_rvalid  in  1  load data valid
i_dmem_rdata  in  XLEN  aligned 8-byte load data

Behaviour:
- Reset (sync, rst=1): state IDLE. All outputs 0, including o_stall and o_dmem_req. An i_dmem_rvalid arriving after reset is ignored.
- Accept: in IDLE with i_valid=1 and i_flush=0, latch addr[2:0], memop, rd_idx, pc and the selected non-load writeback value.
- Non-memory ops (MEMOP_NONE):
  - Latency 1: o_valid=1 next cycle. o_stall=0.
  - o_wb_data = i_exc_csr_valid ? i_exc_csr_out : i_exc_alu_out.
- Misalign check:
  - h: addr[0]≠0. w: addr[1:0]≠0. d: addr[2:0]≠0.
  - If misaligned: no request is issued. Next cycle o_valid=1, o_misalign=1, o_rd_idx=0, o_wb_data=address.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: a valid aligned mem op drives o_dmem_req=1 combinationally in the accept cycle.
    - gnt=1 and store → stays IDLE; o_valid next cycle with rd=0.
    - gnt=1 and load → WAIT.
    - gnt=0 → REQ.
  - REQ: o_dmem_req=1, with addr/we/wdata/wstrb held from the latched copy. On gnt → IDLE (store, result next cycle) or WAIT (load). i_flush in REQ drops the request immediately → IDLE, no result.
  - WAIT: on rvalid, extract the load data; o_valid=1 next cycle; → IDLE. i_flush in WAIT → DRAIN.
  - DRAIN: wait for rvalid, discard the data, emit no o_valid → IDLE.
- o_stall:
  - 1 in REQ/WAIT/DRAIN except the completing cycle (gnt in REQ for a store, rvalid in WAIT).
  - 1 in IDLE when accepting a mem op that does not complete this cycle (i.e. not a store with gnt).
- Store formatting:
  - sb: wdata = 8× rs2[7:0]; wstrb = 8'h01<<a.
  - sh: wdata = 4× rs2[15:0]; wstrb = 8'h03<<a.
  - sw: wdata = 2× rs2[31:0]; wstrb = 8'h0F<<a.
  - sd: wdata = rs2; wstrb = 8'hFF.
  - a = addr[2:0]. o_dmem_addr = full address.
- Load formatting: shifted = rdata >> (8·a); lb/lh/lw sign-extend, lbu/lhu/lwu zero-extend, ld passes through.
- o_valid is deasserted every cycle in which no result completes. o_wb_data, o_rd_idx and o_pc hold their last values while o_valid=0.
- i_flush with i_valid=1 in IDLE: the instruction is not accepted and no result is produced.

Decomposition:
- Shared package/header:
  - MEMOP encodings: NONE=0, LB=1, LH=2, LW=3, LD=4, LBU=5, LHU=6, LWU=7, SB=8, SH=9, SW=10, SD=11.
  - Helpers is_load = op in 1..7, is_store = op in 8..11.
  - FSM state constants.
- One sub-module: lsu_fmt, purely combinational. It computes store wdata/wstrb and load extraction/extension from memop, addr[2:0], rs2 and rdata. The FSM stays in mem_lsu.

Test Plan:
- ALU op, alu_out=0x1234, rd=5 → o_valid next cycle, wb=0x1234, rd=5, stall=0.
- CSR op, csr_valid=1, csr_out=0x1800, rd=7 → next cycle wb=0x1800, rd=7 (alu_out ignored).
- LB addr=0x8000_0003, rdata=0x0000_0000_8000_0000, gnt same cycle, rvalid 2 cycles later:
  - stall held until rvalid; wb=0xFFFF_FFFF_FFFF_FF80.
  - Repeated as LBU: wb=0x80.
- SH addr=0x8000_0006, rs2=0xABCD, gnt delayed 3 cycles:
  - req held in REQ; wstrb=0xC0, wdata=0xABCD_ABCD_ABCD_ABCD.
  - o_valid with rd=0 one cycle after gnt.
- LW addr=0x8000_0002 → no req; o_misalign=1, o_rd_idx=0, wb=0x8000_0002.
- Load in WAIT with i_flush=1, then rvalid → DRAIN, no o_valid, back to IDLE. Separately, rst asserted in WAIT → all outputs 0 next cycle; a later stray rvalid is ignored.
